// File: rtl/feed_ctrl_pkg.sv
// Shared types and sizing helpers for the systolic operand feed controller.
package feed_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } feed_state_e;

  // Drain counter must hold values up to SIZE+PIPE_LAT.
  function automatic int drain_cnt_width(input int size, input int pipe_lat);
    return $clog2(size + pipe_lat + 1);
  endfunction

endpackage

// File: rtl/systolic_feed_ctrl.sv
// Sequences tiles of K-beats into the systolic skew buffer, then waits out the drain.
// Optional stall perf counter enabled by defining FEED_CTRL_PERF_EN.
module systolic_feed_ctrl
  import feed_ctrl_pkg::*;
#(
  parameter int SIZE     = 16,
  parameter int K_WIDTH  = 16,
  parameter int PIPE_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [K_WIDTH-1:0] k_len_i,
  input  logic [K_WIDTH-1:0] num_tiles_i,
  input  logic               src_valid_i,
  output logic               src_ready_o,
  output logic               setup_valid_o,
  output logic               setup_init_o,
  output logic               setup_done_o,
  output logic [K_WIDTH-1:0] tile_idx_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [31:0]        stall_cnt_o
);

  localparam int DRAIN_W   = drain_cnt_width(SIZE, PIPE_LAT);
  localparam int DRAIN_CYC = SIZE + PIPE_LAT - 1;
  // Counter runs LOAD..0 inclusive, giving DRAIN_CYC cycles in DRAIN.
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

  feed_state_e        r_state;
  logic [K_WIDTH-1:0] r_k_len;
  logic [K_WIDTH-1:0] r_num_tiles;
  logic [K_WIDTH-1:0] r_beat_cnt;
  logic [K_WIDTH-1:0] r_tile_idx;
  logic [DRAIN_W-1:0] r_drain_cnt;

  logic w_feed;
  logic w_accept;
  logic w_first_beat;
  logic w_last_beat;
  logic w_last_tile;

  assign w_feed       = (r_state == ST_FEED);
  assign w_accept     = w_feed && src_valid_i;
  assign w_first_beat = (r_beat_cnt == '0);
  assign w_last_beat  = (r_beat_cnt == (r_k_len - K_WIDTH'(1)));
  assign w_last_tile  = (r_tile_idx == (r_num_tiles - K_WIDTH'(1)));

  always_ff @(posedge clk) begin
    if (rst || abort_i) begin
      r_state     <= ST_IDLE;
      r_k_len     <= '0;
      r_num_tiles <= '0;
      r_beat_cnt  <= '0;
      r_tile_idx  <= '0;
      r_drain_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_k_len     <= k_len_i;
            r_num_tiles <= num_tiles_i;
            r_beat_cnt  <= '0;
            r_tile_idx  <= '0;
            r_state     <= ((k_len_i != '0) && (num_tiles_i != '0)) ? ST_FEED : ST_DONE;
          end
        end
        ST_FEED: begin
          if (w_accept) begin
            if (w_last_beat) begin
              r_beat_cnt <= '0;
              if (w_last_tile) begin
                r_drain_cnt <= DRAIN_LOAD;
                r_state     <= (DRAIN_CYC > 0) ? ST_DRAIN : ST_DONE;
              end else begin
                r_tile_idx <= r_tile_idx + K_WIDTH'(1);
              end
            end else begin
              r_beat_cnt <= r_beat_cnt + K_WIDTH'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == '0) begin
            r_state <= ST_DONE;
          end else begin
            r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign src_ready_o   = w_feed;
  assign setup_valid_o = w_accept;
  assign setup_init_o  = w_accept && w_first_beat;
  assign setup_done_o  = w_accept && w_last_beat;
  assign tile_idx_o    = r_tile_idx;
  assign busy_o        = (r_state != ST_IDLE);
  assign done_o        = (r_state == ST_DONE);

`ifdef FEED_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of FEED cycles with no source data; holds after done.
  always_ff @(posedge clk) begin
    if (rst || abort_i) begin
      r_stall_cnt <= '0;
    end else if ((r_state == ST_IDLE) && start_i) begin
      r_stall_cnt <= '0;
    end else if (w_feed && !src_valid_i && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Self-checking bench for systolic_feed_ctrl: directed runs from the test plan plus random runs,
// each checked cycle by cycle against a timeline derived from the beat-acceptance pattern.
module tb_systolic_feed_ctrl;

  localparam int SIZE     = 4;
  localparam int PIPE_LAT = 2;
  localparam int K_WIDTH  = 16;
  localparam int DRAIN    = SIZE + PIPE_LAT;

  logic               clk = 1'b0;
  logic               rst;
  logic               start_i;
  logic               abort_i;
  logic [K_WIDTH-1:0] k_len_i;
  logic [K_WIDTH-1:0] num_tiles_i;
  logic               src_valid_i;
  logic               src_ready_o;
  logic               setup_valid_o;
  logic               setup_init_o;
  logic               setup_done_o;
  logic [K_WIDTH-1:0] tile_idx_o;
  logic               busy_o;
  logic               done_o;
  logic [31:0]        stall_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;
  int run_id  = 0;

  always #5 clk = ~clk;

  systolic_feed_ctrl #(
    .SIZE    (SIZE),
    .K_WIDTH (K_WIDTH),
    .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .k_len_i      (k_len_i),
    .num_tiles_i  (num_tiles_i),
    .src_valid_i  (src_valid_i),
    .src_ready_o  (src_ready_o),
    .setup_valid_o(setup_valid_o),
    .setup_init_o (setup_init_o),
    .setup_done_o (setup_done_o),
    .tile_idx_o   (tile_idx_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: source always valid, 1: random source, 2: source low in cycles 2-3.
  // abort_at / rst_at: cycle in which abort_i / rst is pulsed (-1 for none).
  task automatic do_run(input int k, input int t, input int mode, input int abort_at, input int rst_at);
    bit v[256];
    int need, cnt, last_beat_c, done_c, last_c, kill, beats, stall_exp;
    bit zero;
    bit e_ready, e_valid, e_init, e_sdone, e_busy, e_done;
    int e_tile;
    string pfx;

    run_id++;
    zero = (k == 0) || (t == 0);
    need = k * t;
    cnt = 0;
    last_beat_c = 0;
    stall_exp = 0;
    for (int c = 1; c < 256; c++) begin
      if (!zero && cnt < need) begin
        case (mode)
          0:       v[c] = 1'b1;
          2:       v[c] = !(c == 2 || c == 3);
          default: v[c] = (c > 200) ? 1'b1 : (($urandom % 4) != 0);
        endcase
        if (v[c]) begin
          cnt++;
          if (cnt == need) last_beat_c = c;
        end else begin
          stall_exp++;
        end
      end else begin
        v[c] = 1'($urandom % 2);
      end
    end
    done_c = zero ? 1 : last_beat_c + DRAIN;
    kill   = (abort_at >= 0) ? abort_at : rst_at;
    last_c = (kill >= 0) ? kill + 1 : done_c;

    $display("[TB] run %0d: k_len=%0d tiles=%0d mode=%0d abort_at=%0d rst_at=%0d last_beat=%0d done_cycle=%0d",
             run_id, k, t, mode, abort_at, rst_at, last_beat_c, done_c);

    beats = 0;
    for (int c = 0; c <= last_c; c++) begin
      start_i     = (c == 0) || (zero && c == 1);
      k_len_i     = (c == 0) ? K_WIDTH'(k) : K_WIDTH'(3);
      num_tiles_i = (c == 0) ? K_WIDTH'(t) : K_WIDTH'(2);
      src_valid_i = (c == 0) ? 1'($urandom % 2) : v[c];
      abort_i     = (c == abort_at);
      rst         = (c == rst_at);
      #1;
      e_ready = 0; e_valid = 0; e_init = 0; e_sdone = 0; e_busy = 0; e_done = 0; e_tile = 0;
      if (kill >= 0 && c == kill + 1) begin
        e_tile = 0;
      end else if (c == 0) begin
        e_tile = -1;  // tile index is stale from the previous run here
      end else if (zero) begin
        e_busy = 1; e_done = 1; e_tile = 0;
      end else if (c <= last_beat_c) begin
        e_ready = 1;
        e_busy  = 1;
        e_valid = v[c];
        e_init  = v[c] && (beats % k == 0);
        e_sdone = v[c] && (beats % k == k - 1);
        e_tile  = beats / k;
        if (v[c]) beats++;
      end else begin
        e_busy = 1;
        e_done = (c == done_c);
        e_tile = t - 1;
      end
      pfx = $sformatf("r%0d c%0d", run_id, c);
      check_val({pfx, " src_ready"}, 32'(src_ready_o), 32'(e_ready));
      check_val({pfx, " setup_valid"}, 32'(setup_valid_o), 32'(e_valid));
      check_val({pfx, " setup_init"}, 32'(setup_init_o), 32'(e_init));
      check_val({pfx, " setup_done"}, 32'(setup_done_o), 32'(e_sdone));
      check_val({pfx, " busy"}, 32'(busy_o), 32'(e_busy));
      check_val({pfx, " done"}, 32'(done_o), 32'(e_done));
      if (e_tile >= 0) check_val({pfx, " tile_idx"}, 32'(tile_idx_o), 32'(e_tile));
      if (kill >= 0 && c == kill + 1) begin
        check_val({pfx, " stall_cnt_after_kill"}, stall_cnt_o, 32'd0);
      end else if (kill < 0 && c == done_c) begin
`ifdef FEED_CTRL_PERF_EN
        check_val({pfx, " stall_cnt"}, stall_cnt_o, zero ? 32'd0 : 32'(stall_exp));
`else
        check_val({pfx, " stall_cnt"}, stall_cnt_o, 32'd0);
`endif
      end
      @(negedge clk);
    end
    start_i = 0;
    abort_i = 0;
    rst     = 0;
  endtask

  initial begin
    rst = 1; start_i = 0; abort_i = 0; src_valid_i = 0;
    k_len_i = '0; num_tiles_i = '0;
    repeat (3) @(negedge clk);
    src_valid_i = 1;
    #1;
    check_val("reset src_ready", 32'(src_ready_o), 32'd0);
    check_val("reset setup_valid", 32'(setup_valid_o), 32'd0);
    check_val("reset busy", 32'(busy_o), 32'd0);
    check_val("reset done", 32'(done_o), 32'd0);
    check_val("reset tile_idx", 32'(tile_idx_o), 32'd0);
    check_val("reset stall_cnt", stall_cnt_o, 32'd0);
    @(negedge clk);
    rst = 0;
    src_valid_i = 0;
    @(negedge clk);

    do_run(3, 1, 0, -1, -1);   // basic
    do_run(2, 3, 0, -1, -1);   // multi-tile
    do_run(1, 2, 0, -1, -1);   // single-beat tiles
    do_run(4, 1, 2, -1, -1);   // source stall in cycles 2-3
    do_run(0, 2, 0, -1, -1);   // zero length, restart attempt in cycle 1 ignored
    do_run(2, 1, 0, 4, -1);    // abort during drain
    do_run(3, 2, 1, -1, 3);    // reset during feed
    do_run(2, 2, 1, -1, -1);   // normal run after kills
    do_run(3, 0, 1, -1, -1);   // zero tiles
    for (int i = 0; i < 20; i++) begin
      do_run(int'($urandom_range(1, 5)), int'($urandom_range(1, 3)), 1, -1, -1);
    end
    do_run(3, 3, 1, 5, -1);    // abort during feed

    #1;
    check_val("final idle busy", 32'(busy_o), 32'd0);
    check_val("final idle done", 32'(done_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
